// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS32 multiply/divide unit.
//   - Op encodings presented on the Op port of muldiv_unit.
//   - FSM state encoding used by muldiv_unit.
//   - Small decode helpers for the op field.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } mdu_state_e;

    // Ops 0-3 are the iterative arithmetic ops.
    function automatic logic mdu_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   div_i  : 0 = multiply add-shift, 1 = restoring divide trial-subtract/shift
//   hi_i   : multiply: upper product half; divide: partial remainder
//   lo_i   : multiply: multiplier / lower product half; divide: dividend / quotient
//   opb_i  : multiply: multiplicand; divide: divisor (unsigned magnitudes)
//   hi_o   : next upper half / remainder
//   lo_o   : next lower half / quotient
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift
        // the whole {hi, lo} pair right, keeping the carry.
        addend  = lo_i[0] ? opb_i : '0;
        sum     = {1'b0, hi_i} + {1'b0, addend};

        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        // The partial remainder stays below the divisor, so the low WIDTH bits of
        // the modular difference are exact whenever there is no borrow.
        shifted = {hi_i, lo_i[WIDTH-1]};
        borrow  = (shifted < {1'b0, opb_i});
        diff    = shifted[WIDTH-1:0] - opb_i;

        if (div_i) begin
            hi_o = borrow ? shifted[WIDTH-1:0] : diff;
            lo_o = {lo_i[WIDTH-2:0], ~borrow};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MIPS32 EX stage).
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   Start, Op     : launch MULT/MULTU/DIV/DIVU/MTHI/MTLO with operands Rs, Rt
//   Cancel        : abort an in-flight op on pipeline flush
//   Busy          : arithmetic op in flight
//   Done          : one-cycle pulse when an arithmetic op has written HI/LO
//   DivByZero     : qualifies Done; the divisor was zero
//   HI, LO        : architectural result registers
// Optional build macro MULDIV_EARLY_OUT_EN: zero operands skip the iteration.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Rt,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned N  = WIDTH / UNROLL;
    localparam int unsigned CW = $clog2(N);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d, rs_q, rs_d;
    logic             div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d, done_q, done_d, dbz_out_q, dbz_out_d;

    // Launch decode
    logic             sgn, op_div, early;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        sgn    = mdu_is_signed(Op);
        op_div = mdu_is_div(Op);
        mag_a  = (sgn && Rs[WIDTH-1]) ? -Rs : Rs;
        mag_b  = (sgn && Rt[WIDTH-1]) ? -Rt : Rt;
`ifdef MULDIV_EARLY_OUT_EN
        early  = op_div ? ((Rs == '0) && (Rt != '0)) : ((Rs == '0) || (Rt == '0));
`else
        early  = 1'b0;
`endif
    end

    // Step chain. The first group of steps runs on the launch edge straight from
    // the operand magnitudes, so CALC only needs N-1 cycles and SIGN fits inside
    // the N busy cycles.
    logic             chain_div;
    logic [WIDTH-1:0] chain_opb, chain_hi, chain_lo;
    logic [WIDTH-1:0] hi_c [UNROLL+1];
    logic [WIDTH-1:0] lo_c [UNROLL+1];

    always_comb begin
        if (state_q == IDLE) begin
            chain_div = op_div;
            chain_opb = mag_b;
            chain_hi  = '0;
            chain_lo  = mag_a;
        end else begin
            chain_div = div_q;
            chain_opb = opb_q;
            chain_hi  = acc_hi_q;
            chain_lo  = acc_lo_q;
        end
    end

    assign hi_c[0] = chain_hi;
    assign lo_c[0] = chain_lo;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        mdu_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .div_i (chain_div),
            .hi_i  (hi_c[g]),
            .lo_i  (lo_c[g]),
            .opb_i (chain_opb),
            .hi_o  (hi_c[g+1]),
            .lo_o  (lo_c[g+1])
        );
    end

    // Sign correction of the unsigned result
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? -prod : prod;
        if (!div_q) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
            hi_fix = rs_q;
            lo_fix = '1;
        end else begin
            // Most-negative / -1 falls out naturally: negating 2^(WIDTH-1) wraps.
            hi_fix = neg_rem_q ? -acc_hi_q : acc_hi_q;
            lo_fix = neg_q ? -acc_lo_q : acc_lo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        rs_d      = rs_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Cancel beats a same-cycle Start.
                if (Start && !Cancel) begin
                    if (mdu_is_arith(Op)) begin
                        acc_hi_d  = hi_c[UNROLL];
                        acc_lo_d  = lo_c[UNROLL];
                        opb_d     = mag_b;
                        rs_d      = Rs;
                        div_d     = op_div;
                        neg_d     = sgn && (Rs[WIDTH-1] ^ Rt[WIDTH-1]);
                        neg_rem_d = sgn && Rs[WIDTH-1];
                        dbz_d     = op_div && (Rt == '0);
                        cnt_d     = CW'(1);
                        state_d   = CALC;
                        if (early) begin
                            acc_hi_d = '0;
                            acc_lo_d = '0;
                            state_d  = SIGN;
                        end
                    end else if (Op == MDU_MTHI) begin
                        hi_d = Rs;
                    end else if (Op == MDU_MTLO) begin
                        lo_d = Rs;
                    end
                end
            end
            CALC: begin
                if (Cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_hi_d = hi_c[UNROLL];
                    acc_lo_d = lo_c[UNROLL];
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = SIGN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SIGN: begin
                state_d = IDLE;
                if (!Cancel) begin
                    hi_d      = hi_fix;
                    lo_d      = lo_fix;
                    done_d    = 1'b1;
                    dbz_out_d = dbz_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            rs_q      <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            rs_q      <= rs_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_out_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: one instance with UNROLL=1 and one
// with UNROLL=4. Cycle numbers count from the Start edge k: cycle k+1 is the
// period right after that edge.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start1, cancel1, busy1, done1, dbz1;
    logic [2:0]  op1;
    logic [31:0] rs1, rt1, hi1, lo1;
    logic        start4, cancel4, busy4, done4, dbz4;
    logic [2:0]  op4;
    logic [31:0] rs4, rt4, hi4, lo4;

    int vectors = 0;
    int errors  = 0;

    muldiv_unit #(
        .WIDTH  (32),
        .UNROLL (1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .Start     (start1),
        .Op        (op1),
        .Rs        (rs1),
        .Rt        (rt1),
        .Cancel    (cancel1),
        .Busy      (busy1),
        .Done      (done1),
        .DivByZero (dbz1),
        .HI        (hi1),
        .LO        (lo1)
    );

    muldiv_unit #(
        .WIDTH  (32),
        .UNROLL (4)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .Start     (start4),
        .Op        (op4),
        .Rs        (rs4),
        .Rt        (rt4),
        .Cancel    (cancel4),
        .Busy      (busy4),
        .Done      (done4),
        .DivByZero (dbz4),
        .HI        (hi4),
        .LO        (lo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one op and watch 40 cycles. Optionally inject a second Start
    // (MULTU 7*11) or a Cancel during cycle k+inj_cyc / k+cancel_cyc.
    task automatic run_op(input bit u4, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj_cyc, input int cancel_cyc,
                          output int done_cyc, output int done_cnt, output int busy_cnt,
                          output int busy_first, output logic [31:0] hi_at,
                          output logic [31:0] lo_at, output logic dbz_at);
        logic bz, dn;
        @(negedge clk);
        if (u4) begin
            start4 = 1'b1; op4 = op; rs4 = a; rt4 = b;
        end else begin
            start1 = 1'b1; op1 = op; rs1 = a; rt1 = b;
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1;
        hi_at = 'x; lo_at = 'x; dbz_at = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start1 = 1'b0; cancel1 = 1'b0; start4 = 1'b0; cancel4 = 1'b0;
            bz = u4 ? busy4 : busy1;
            dn = u4 ? done4 : done1;
            if (bz) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
            end
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    hi_at    = u4 ? hi4 : hi1;
                    lo_at    = u4 ? lo4 : lo1;
                    dbz_at   = u4 ? dbz4 : dbz1;
                end
            end
            if (c == inj_cyc) begin
                if (u4) begin
                    start4 = 1'b1; op4 = 3'd1; rs4 = 32'd7; rt4 = 32'd11;
                end else begin
                    start1 = 1'b1; op1 = 3'd1; rs1 = 32'd7; rt1 = 32'd11;
                end
            end
            if (c == cancel_cyc) begin
                if (u4) cancel4 = 1'b1;
                else    cancel1 = 1'b1;
            end
        end
        start1 = 1'b0; cancel1 = 1'b0; start4 = 1'b0; cancel4 = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy1, done1, dbz1, busy4, done4, dbz4} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy1, done1, dbz1, busy4, done4, dbz4});
        end
        vectors++;
        if ({hi1, lo1} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h want 0_0", hi1, lo1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy1, done1, hi4, lo4} !== 66'h0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b hi4=%h lo4=%h want 0",
                     busy1, done1, hi4, lo4);
        end
    endtask

    task automatic test_mult();
        int dc, dn, bc, bf;
        logic [31:0] h, l;
        logic z;
        run_op(1'b0, 3'd0, 32'hFFFF_FFFE, 32'd3, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dc !== 33) begin
            errors++; $display("FAIL mult_latency: got %0d want 33", dc);
        end
        vectors++;
        if (bc !== 32 || bf !== 1) begin
            errors++; $display("FAIL mult_busy: got cnt=%0d first=%0d want 32/1", bc, bf);
        end
        vectors++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA || z !== 1'b0) begin
            errors++;
            $display("FAIL mult_result: got %h_%h dbz=%b want ffffffff_fffffffa dbz=0",
                     h, l, z);
        end
        vectors++;
        if (dn !== 1) begin
            errors++; $display("FAIL mult_done_pulse: got %0d pulses want 1", dn);
        end
    endtask

    task automatic test_div();
        int dc, dn, bc, bf;
        logic [31:0] h, l;
        logic z;
        run_op(1'b0, 3'd3, 32'd100, 32'd7, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dc !== 33 || h !== 32'd2 || l !== 32'd14) begin
            errors++;
            $display("FAIL divu_100_7: got cyc=%0d hi=%h lo=%h want 33/2/e", dc, h, l);
        end
        run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD || z !== 1'b0) begin
            errors++;
            $display("FAIL div_m7_2: got hi=%h lo=%h dbz=%b want ffffffff/fffffffd/0",
                     h, l, z);
        end
    endtask

    task automatic test_div_edge();
        int dc, dn, bc, bf;
        logic [31:0] h, l;
        logic z;
        run_op(1'b0, 3'd2, 32'd5, 32'd0, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dc !== 33 || z !== 1'b1 || h !== 32'd5 || l !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_by_zero: got cyc=%0d dbz=%b hi=%h lo=%h want 33/1/5/ffffffff",
                     dc, z, h, l);
        end
        run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (h !== 32'h0 || l !== 32'h8000_0000 || z !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b want 0/80000000/0", h, l, z);
        end
    endtask

    task automatic test_mt();
        @(negedge clk);
        start1 = 1'b1; op1 = 3'd4; rs1 = 32'h1234;
        @(posedge clk);
        #1;
        vectors++;
        if (hi1 !== 32'h1234 || lo1 !== 32'h8000_0000) begin
            errors++; $display("FAIL mthi: got hi=%h lo=%h want 1234/80000000", hi1, lo1);
        end
        op1 = 3'd5; rs1 = 32'h5678;
        @(posedge clk);
        #1;
        vectors++;
        if (hi1 !== 32'h1234 || lo1 !== 32'h5678 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h done=%b busy=%b want 1234/5678/0/0",
                     hi1, lo1, done1, busy1);
        end
        op1 = 3'd6; rs1 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(negedge clk);
        vectors++;
        if (hi1 !== 32'h1234 || lo1 !== 32'h5678 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL unused_op: got hi=%h lo=%h done=%b busy=%b want 1234/5678/0/0",
                     hi1, lo1, done1, busy1);
        end
    endtask

    task automatic test_start_while_busy();
        int dc, dn, bc, bf;
        logic [31:0] h, l;
        logic z;
        run_op(1'b0, 3'd1, 32'd3, 32'd5, 5, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dc !== 33 || dn !== 1 || h !== 32'h0 || l !== 32'd15) begin
            errors++;
            $display("FAIL start_while_busy: got cyc=%0d pulses=%0d hi=%h lo=%h want 33/1/0/f",
                     dc, dn, h, l);
        end
    endtask

    task automatic test_cancel();
        int dc, dn, bc, bf, seen;
        logic [31:0] h, l;
        logic z;
        run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 10, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dn !== 0 || bc !== 10) begin
            errors++;
            $display("FAIL cancel_calc: got pulses=%0d busy_cycles=%0d want 0/10", dn, bc);
        end
        vectors++;
        if (hi1 !== 32'h0 || lo1 !== 32'd15) begin
            errors++; $display("FAIL cancel_hilo: got hi=%h lo=%h want 0/f", hi1, lo1);
        end
        // Cancel together with Start in IDLE launches nothing
        @(negedge clk);
        start1 = 1'b1; op1 = 3'd1; rs1 = 32'd9; rt1 = 32'd9; cancel1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; cancel1 = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy1 || done1) seen++;
        end
        vectors++;
        if (seen !== 0 || lo1 !== 32'd15) begin
            errors++;
            $display("FAIL cancel_with_start: got active=%0d lo=%h want 0/f", seen, lo1);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        start1 = 1'b1; op1 = 3'd1; rs1 = 32'hFFFF_FFFF; rt1 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy1);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy1, done1, dbz1, hi1, lo1} !== 67'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got busy=%b done=%b dbz=%b hi=%h lo=%h want 0",
                     busy1, done1, dbz1, hi1, lo1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy1 !== 1'b0 || lo1 !== 32'h0) begin
            errors++; $display("FAIL rst_mid_idle: got busy=%b lo=%h want 0/0", busy1, lo1);
        end
    endtask

    task automatic test_unroll4();
        int dc, dn, bc, bf;
        logic [31:0] h, l;
        logic z;
        run_op(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dc !== 9 || bc !== 8) begin
            errors++;
            $display("FAIL u4_latency: got cyc=%0d busy_cycles=%0d want 9/8", dc, bc);
        end
        vectors++;
        if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
            errors++; $display("FAIL u4_multu: got %h_%h want fffffffe_00000001", h, l);
        end
        run_op(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (dc !== 9 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL u4_div: got cyc=%0d hi=%h lo=%h want 9/ffffffff/fffffffd", dc, h, l);
        end
        run_op(1'b1, 3'd0, 32'd0, 32'd5, -1, -1, dc, dn, bc, bf, h, l, z);
        vectors++;
        if (h !== 32'h0 || l !== 32'h0 || dn !== 1) begin
            errors++;
            $display("FAIL u4_mult_zero: got hi=%h lo=%h pulses=%0d want 0/0/1", h, l, dn);
        end
`ifdef MULDIV_EARLY_OUT_EN
        vectors++;
        if (dc !== 2 || bc !== 1) begin
            errors++;
            $display("FAIL u4_early_out: got cyc=%0d busy_cycles=%0d want 2/1", dc, bc);
        end
`else
        vectors++;
        if (dc !== 9 || bc !== 8) begin
            errors++;
            $display("FAIL u4_zero_full: got cyc=%0d busy_cycles=%0d want 9/8", dc, bc);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        start1 = 1'b0; cancel1 = 1'b0; op1 = '0; rs1 = '0; rt1 = '0;
        start4 = 1'b0; cancel4 = 1'b0; op4 = '0; rs4 = '0; rt4 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mt();
        test_start_while_busy();
        test_cancel();
        test_reset_mid_op();
        test_unroll4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
